// File: rtl/fill_seal_line_ctrl_if.sv
// Command/status bundle between the line sequencer and the filler/sealer controller.
// The sequencer drives the commands; the controller drives the actuators and status.
interface fill_seal_line_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             startfill;
  logic             abort;
  logic             productook;
  logic             clear_fault;
  logic             llenando;
  logic             sellando;
  logic             LED;
  logic             fault;
  logic [2:0]       state_filler;
  logic [2:0]       state_sealer;
  logic [CNT_W-1:0] good_count;

  modport master (
    output startfill, abort, productook, clear_fault,
    input  llenando, sellando, LED, fault, state_filler, state_sealer, good_count
  );

  modport slave (
    input  startfill, abort, productook, clear_fault,
    output llenando, sellando, LED, fault, state_filler, state_sealer, good_count
  );
endinterface

// File: rtl/fill_seal_line_ctrl.sv
// Moore filler FSM and Mealy sealer FSM joined by a full/accept handshake, so the
// next fill overlaps the current seal; adds inspection timeout fault and good count.
module fill_seal_line_ctrl #(
  parameter int FILL_CYCLES = 8,
  parameter int SEAL_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fill_seal_line_ctrl_if.slave  bus
);
  localparam int FW   = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int SMAX = (SEAL_CYCLES > TIMEOUT) ? SEAL_CYCLES : TIMEOUT;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);
  localparam logic [SW-1:0] SEAL_LAST = SW'(SEAL_CYCLES - 1);
  localparam logic [SW-1:0] TMO_LAST  = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_FILL = 3'd1,
    F_FULL = 3'd2
  } fstate_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEAL    = 3'd1,
    S_WAIT_OK = 3'd2,
    S_FAULT   = 3'd3
  } sstate_e;

  fstate_e          f_q, f_d;
  sstate_e          s_q, s_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             accept;

  assign accept = (f_q == F_FULL) && (s_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= F_IDLE;
      s_q    <= S_IDLE;
      fcnt_q <= '0;
      scnt_q <= '0;
      good_q <= '0;
    end else begin
      f_q    <= f_d;
      s_q    <= s_d;
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
      good_q <= good_d;
    end
  end

  // Filler: abort beats fill completion, so an aborted last cycle yields no product.
  always_comb begin
    f_d    = f_q;
    fcnt_d = fcnt_q;
    case (f_q)
      F_IDLE: if (bus.startfill) begin
        f_d    = F_FILL;
        fcnt_d = '0;
      end
      F_FILL: begin
        if (bus.abort)                f_d = F_IDLE;
        else if (fcnt_q == FILL_LAST) f_d = F_FULL;
        else                          fcnt_d = fcnt_q + FW'(1);
      end
      F_FULL: if (accept) f_d = F_IDLE;
      default: f_d = F_IDLE;
    endcase
  end

  // Sealer: one counter serves both the seal duration and the inspection timeout.
  always_comb begin
    s_d    = s_q;
    scnt_d = scnt_q;
    good_d = good_q;
    case (s_q)
      S_IDLE: if (accept) begin
        s_d    = S_SEAL;
        scnt_d = '0;
      end
      S_SEAL: begin
        if (scnt_q == SEAL_LAST) begin
          s_d    = S_WAIT_OK;
          scnt_d = '0;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_WAIT_OK: begin
        if (bus.productook) begin
          s_d = S_IDLE;
          if (good_q != '1) good_d = good_q + CNT_W'(1);
        end else if (scnt_q == TMO_LAST) begin
          s_d = S_FAULT;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_FAULT: if (bus.clear_fault) s_d = S_IDLE;
      default: s_d = S_IDLE;
    endcase
  end

  assign bus.llenando     = (f_q == F_FILL);
  assign bus.sellando     = (s_q == S_SEAL);
  assign bus.fault        = (s_q == S_FAULT);
  assign bus.LED          = (s_q == S_WAIT_OK) && bus.productook;
  assign bus.state_filler = f_q;
  assign bus.state_sealer = s_q;
  assign bus.good_count   = good_q;
endmodule

// File: doc/fill_seal_line_ctrl.md
Name: fill_seal_line_ctrl

Overview:
Parametrised successor of the two-FSM filler/sealer controller. A Moore filler FSM and a Mealy sealer FSM share a full/accept handshake, so the next fill overlaps the current seal. Adds programmable fill and seal durations, a productook timeout with latched fault, fill abort, and a saturating good-product counter. Sits directly under the top-level wrapper, driving the fill valve, seal head and status LED.

Parameters:
FILL_CYCLES, 8, cycles llenando stays high per product (>=1)
SEAL_CYCLES, 4, cycles sellando stays high per product (>=1)
TIMEOUT, 16, max cycles in S_WAIT_OK before fault (>=1)
CNT_W, 8, width of good_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
startfill  input  1  request to start a fill (level, sampled in F_IDLE)
abort  input  1  discard the fill in progress
productook  input  1  inspection pass for the sealed product
clear_fault  input  1  leave S_FAULT
llenando  output  1  fill valve on (Moore)
sellando  output  1  seal head on (Moore)
LED  output  1  good-product indicator (Mealy)
fault  output  1  timeout fault latched
state_filler  output  3  filler state code
state_sealer  output  3  sealer state code
good_count  output  CNT_W  accepted products, saturating

Behaviour:
- Reset: both FSMs at IDLE (code 0); all counters 0. Every output is 0 during reset and in the cycle after reset release.
- Filler codes: F_IDLE=0, F_FILL=1, F_FULL=2. Sealer codes: S_IDLE=0, S_SEAL=1, S_WAIT_OK=2, S_FAULT=3. Codes 4-7 are unused and go to IDLE on the next cycle.
- Internal lleno_flag = (filler==F_FULL). accept = lleno_flag & (sealer==S_IDLE).
- F_IDLE: when startfill=1, go to F_FILL and clear the fill counter.
- F_FILL: llenando=1. The counter increments each cycle. When count==FILL_CYCLES-1, go to F_FULL, so llenando is high for exactly FILL_CYCLES cycles.
  - abort=1 in F_FILL: go to F_IDLE next cycle; no product is produced.
  - abort has no effect in any other state.
- F_FULL: llenando=0. Hold until accept; on accept go to F_IDLE next cycle. This is backpressure: the filler waits while the sealer is busy or faulted.
- S_IDLE: on accept go to S_SEAL and clear the seal counter.
- S_SEAL: sellando=1 for exactly SEAL_CYCLES cycles, then go to S_WAIT_OK with the timeout counter cleared.
- S_WAIT_OK: LED = productook, combinationally in the same cycle.
  - productook=1: go to S_IDLE and increment good_count, saturating at 2^CNT_W-1.
  - Otherwise the timeout counter increments. At count==TIMEOUT-1 with productook=0, go to S_FAULT.
  - productook=1 on the final timeout cycle wins: the product is counted and there is no fault.
- S_FAULT: fault=1, LED=0. Stay until clear_fault=1, then go to S_IDLE. good_count is unchanged. clear_fault is ignored in every other state.
- Overlap: the filler may be in F_FILL while the sealer is in S_SEAL or S_WAIT_OK. A new fill can start the cycle after the filler returns to F_IDLE.
- rst asserted in any state returns both FSMs to IDLE on the next edge. An in-flight product is lost and is not counted.
- The Mealy path is only productook -> LED. Every other output comes directly from registers.

Test Plan:
- Single product, defaults: startfill pulse at cycle 0 -> llenando high cycles 1-8; accept; sellando high 4 cycles; productook=1 in S_WAIT_OK -> LED=1 that cycle; good_count=1; both FSMs back to 0.
- Pipelining: startfill held high -> second fill runs while the first product is being sealed. After 3 products with immediate productook, good_count=3 and llenando never asserts during F_FULL.
- Backpressure and timeout: productook held at 0 -> fault=1 and state_sealer=3 after 16 cycles in S_WAIT_OK. Second filled product waits in F_FULL (state_filler=2). clear_fault -> sealer accepts it on the next S_IDLE cycle; good_count unchanged.
- Timeout boundary: productook=1 exactly on cycle 16 of S_WAIT_OK -> no fault, good_count increments.
- Abort: abort=1 on the 3rd F_FILL cycle -> llenando=0 next cycle, state_filler=0, sealer stays at 0, good_count unchanged.
- Reset and saturation: with CNT_W=2, 5 good products -> good_count=3. Assert rst during S_SEAL -> all outputs 0 next cycle, good_count=0.
